// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the clock block while hour/minute are edited in shadow
// registers, then issues a one-cycle load on commit or silently aborts on idle timeout.
module clock_set_ctrl #(
    parameter int unsigned HOURS     = 24,
    parameter int unsigned MINUTES   = 60,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       clk_en,
    output logic       load,
    output logic [4:0] set_hour,
    output logic [5:0] set_minute,
    output logic [1:0] edit_sel,
    output logic       blink
);

    localparam int unsigned IdleW  = (TIMEOUT > 2)   ? $clog2(TIMEOUT)   : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [4:0]        HourMax  = 5'(HOURS - 1);
    localparam logic [5:0]        MinMax   = 6'(MINUTES - 1);
    localparam logic [IdleW-1:0]  IdleMax  = IdleW'(TIMEOUT - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

    // Encoding doubles as the edit_sel output.
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StCommit  = 2'b11
    } state_e;

    state_e            r_state;
    logic              r_clk_en;
    logic              r_load;
    logic [4:0]        r_hour;
    logic [5:0]        r_min;
    logic              r_blink;
    logic [IdleW-1:0]  r_idle;
    logic [BlinkW-1:0] r_blink_cnt;

    state_e            w_state_d;
    logic              w_clk_en_d;
    logic              w_load_d;
    logic [4:0]        w_hour_d;
    logic [5:0]        w_min_d;
    logic              w_blink_d;
    logic [IdleW-1:0]  w_idle_d;
    logic [BlinkW-1:0] w_blink_cnt_d;

    logic              w_any_btn;
    logic              w_inc_only;
    logic              w_dec_only;
    logic              w_in_set;
    logic              w_timeout;
    logic [4:0]        w_hour_inc;
    logic [4:0]        w_hour_dec;
    logic [5:0]        w_min_inc;
    logic [5:0]        w_min_dec;
    logic [4:0]        w_cap_hour;
    logic [5:0]        w_cap_min;

    assign w_any_btn  = btn_mode | btn_inc | btn_dec;
    assign w_inc_only = btn_inc & ~btn_dec;
    assign w_dec_only = btn_dec & ~btn_inc;
    assign w_in_set   = (r_state == StSetHour) || (r_state == StSetMin);
    assign w_timeout  = w_in_set && !w_any_btn && (r_idle == IdleMax);

    // Wrap tests are done before the add/subtract so no wider sum is ever formed.
    assign w_hour_inc = (r_hour == HourMax) ? 5'd0 : r_hour + 5'd1;
    assign w_hour_dec = (r_hour == 5'd0) ? HourMax : r_hour - 5'd1;
    assign w_min_inc  = (r_min == MinMax) ? 6'd0 : r_min + 6'd1;
    assign w_min_dec  = (r_min == 6'd0) ? MinMax : r_min - 6'd1;

    assign w_cap_hour = (cur_hour > HourMax) ? 5'd0 : cur_hour;
    assign w_cap_min  = (cur_minute > MinMax) ? 6'd0 : cur_minute;

    always_comb begin
        w_state_d = r_state;
        w_hour_d  = r_hour;
        w_min_d   = r_min;

        unique case (r_state)
            StRun: begin
                if (btn_mode) begin
                    w_state_d = StSetHour;
                    w_hour_d  = w_cap_hour;
                    w_min_d   = w_cap_min;
                end
            end
            StSetHour: begin
                if (btn_mode) begin
                    w_state_d = StSetMin;
                end else if (w_inc_only) begin
                    w_hour_d = w_hour_inc;
                end else if (w_dec_only) begin
                    w_hour_d = w_hour_dec;
                end else if (w_timeout) begin
                    w_state_d = StRun;
                end
            end
            StSetMin: begin
                if (btn_mode) begin
                    w_state_d = StCommit;
                end else if (w_inc_only) begin
                    w_min_d = w_min_inc;
                end else if (w_dec_only) begin
                    w_min_d = w_min_dec;
                end else if (w_timeout) begin
                    w_state_d = StRun;
                end
            end
            StCommit: begin
                w_state_d = StRun;
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    always_comb begin
        w_idle_d      = '0;
        w_blink_d     = 1'b0;
        w_blink_cnt_d = '0;
        w_clk_en_d    = (w_state_d == StRun);
        w_load_d      = (w_state_d == StCommit);

        if ((w_state_d == r_state) && w_in_set && !w_any_btn) begin
            w_idle_d = r_idle + IdleW'(1);
        end

        // Blink restarts high on entry to either edit field.
        if ((w_state_d == StSetHour) || (w_state_d == StSetMin)) begin
            if (w_state_d != r_state) begin
                w_blink_d     = 1'b1;
                w_blink_cnt_d = '0;
            end else if (r_blink_cnt == BlinkMax) begin
                w_blink_d     = ~r_blink;
                w_blink_cnt_d = '0;
            end else begin
                w_blink_d     = r_blink;
                w_blink_cnt_d = r_blink_cnt + BlinkW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= StRun;
            r_clk_en    <= 1'b1;
            r_load      <= 1'b0;
            r_hour      <= 5'd0;
            r_min       <= 6'd0;
            r_blink     <= 1'b0;
            r_idle      <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_clk_en    <= w_clk_en_d;
            r_load      <= w_load_d;
            r_hour      <= w_hour_d;
            r_min       <= w_min_d;
            r_blink     <= w_blink_d;
            r_idle      <= w_idle_d;
            r_blink_cnt <= w_blink_cnt_d;
        end
    end

    assign clk_en     = r_clk_en;
    assign load       = r_load;
    assign set_hour   = r_hour;
    assign set_minute = r_min;
    assign edit_sel   = r_state;
    assign blink      = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed-vector bench for clock_set_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_clock_set_ctrl;

    logic       clk;
    logic       rstn;
    logic [4:0] cur_hour;
    logic [5:0] cur_minute;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic       clk_en;
    logic       load;
    logic [4:0] set_hour;
    logic [5:0] set_minute;
    logic [1:0] edit_sel;
    logic       blink;

    clock_set_ctrl #(
        .HOURS    (24),
        .MINUTES  (60),
        .TIMEOUT  (64),
        .BLINK_DIV(8)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .cur_hour  (cur_hour),
        .cur_minute(cur_minute),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .clk_en    (clk_en),
        .load      (load),
        .set_hour  (set_hour),
        .set_minute(set_minute),
        .edit_sel  (edit_sel),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mask bits: [5] clk_en, [4] load, [3] hour, [2] minute, [1] edit_sel, [0] blink.
    localparam logic [5:0] MAll = 6'h3f;
    localparam logic [5:0] MCtl = 6'h32;  // clk_en, load, edit_sel

    typedef struct {
        string      name;
        int         cyc;
        logic [5:0] mask;
        logic       en;
        logic       ld;
        logic [4:0] hour;
        logic [5:0] minute;
        logic [1:0] sel;
        logic       bl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = 1'b1;
            if (e.mask[5] && clk_en !== e.en)         ok = 1'b0;
            if (e.mask[4] && load !== e.ld)           ok = 1'b0;
            if (e.mask[3] && set_hour !== e.hour)     ok = 1'b0;
            if (e.mask[2] && set_minute !== e.minute) ok = 1'b0;
            if (e.mask[1] && edit_sel !== e.sel)      ok = 1'b0;
            if (e.mask[0] && blink !== e.bl)          ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s @cyc %0d mask=%b: got en=%b ld=%b h=%0d m=%0d sel=%b bl=%b, want en=%b ld=%b h=%0d m=%0d sel=%b bl=%b",
                         e.name, cyc, e.mask, clk_en, load, set_hour, set_minute, edit_sel,
                         blink, e.en, e.ld, e.hour, e.minute, e.sel, e.bl);
            end
        end
    end

    task automatic step(input string name, input bit m, input bit i, input bit d,
                        input logic [5:0] mask, input logic en, input logic ld,
                        input logic [4:0] h, input logic [5:0] mi, input logic [1:0] sel,
                        input logic bl);
        exp_t e;
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        e.name   = name;
        e.cyc    = cyc + 1;
        e.mask   = mask;
        e.en     = en;
        e.ld     = ld;
        e.hour   = h;
        e.minute = mi;
        e.sel    = sel;
        e.bl     = bl;
        q.push_back(e);
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        cur_hour   = 5'd10;
        cur_minute = 6'd30;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        btn_dec    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", 0, 0, 0, MAll, 1, 0, 0, 0, 2'b00, 0);
        rstn = 1'b1;

        step("run_ignores_dec", 0, 0, 1, MAll, 1, 0, 0, 0, 2'b00, 0);
        step("run_ignores_inc", 0, 1, 0, MAll, 1, 0, 0, 0, 2'b00, 0);
        step("enter_hour", 1, 0, 0, MAll, 0, 0, 10, 30, 2'b01, 1);
        for (int k = 1; k <= 7; k++) step("blink_hold", 0, 0, 0, MAll, 0, 0, 10, 30, 2'b01, 1);
        step("blink_toggle", 0, 0, 0, MAll, 0, 0, 10, 30, 2'b01, 0);
        step("hour_inc1", 0, 1, 0, MAll, 0, 0, 11, 30, 2'b01, 0);
        step("hour_inc2", 0, 1, 0, MAll, 0, 0, 12, 30, 2'b01, 0);
        step("enter_min", 1, 0, 0, MAll, 0, 0, 12, 30, 2'b10, 1);
        step("min_dec", 0, 0, 1, MAll, 0, 0, 12, 29, 2'b10, 1);
        step("commit", 1, 0, 0, MAll, 0, 1, 12, 29, 2'b11, 0);
        step("after_commit", 0, 0, 0, MAll, 1, 0, 12, 29, 2'b00, 0);
        step("hold_shadow", 0, 0, 0, MAll, 1, 0, 12, 29, 2'b00, 0);

        cur_hour   = 5'd23;
        cur_minute = 6'd59;
        step("wrap_enter", 1, 0, 0, MAll, 0, 0, 23, 59, 2'b01, 1);
        step("hour_wrap_up", 0, 1, 0, MAll, 0, 0, 0, 59, 2'b01, 1);
        step("hour_wrap_dn", 0, 0, 1, MAll, 0, 0, 23, 59, 2'b01, 1);
        step("wrap_min", 1, 0, 0, MAll, 0, 0, 23, 59, 2'b10, 1);
        step("min_wrap_up", 0, 1, 0, MAll, 0, 0, 23, 0, 2'b10, 1);
        step("min_wrap_dn", 0, 0, 1, MAll, 0, 0, 23, 59, 2'b10, 1);
        step("min_dec58", 0, 0, 1, MAll, 0, 0, 23, 58, 2'b10, 1);
        step("wrap_commit", 1, 0, 0, MAll, 0, 1, 23, 58, 2'b11, 0);
        step("wrap_run", 0, 0, 0, MAll, 1, 0, 23, 58, 2'b00, 0);

        cur_hour   = 5'd7;
        cur_minute = 6'd7;
        step("to_enter", 1, 0, 0, MAll, 0, 0, 7, 7, 2'b01, 1);
        for (int k = 1; k <= 63; k++) step("to_wait", 0, 0, 0, MCtl, 0, 0, 0, 0, 2'b01, 0);
        step("to_abort", 0, 0, 0, MAll, 1, 0, 7, 7, 2'b00, 0);

        step("to2_enter", 1, 0, 0, MAll, 0, 0, 7, 7, 2'b01, 1);
        for (int k = 1; k <= 39; k++) step("to2_wait", 0, 0, 0, MCtl, 0, 0, 0, 0, 2'b01, 0);
        step("to2_inc", 0, 1, 0, MCtl | 6'h08, 0, 0, 8, 0, 2'b01, 0);
        for (int k = 1; k <= 63; k++) step("to2_wait2", 0, 0, 0, MCtl, 0, 0, 0, 0, 2'b01, 0);
        step("to2_abort", 0, 0, 0, MAll, 1, 0, 8, 7, 2'b00, 0);

        cur_hour   = 5'd5;
        cur_minute = 6'd10;
        step("sim_enter", 1, 0, 0, MAll, 0, 0, 5, 10, 2'b01, 1);
        step("mode_plus_inc", 1, 1, 0, MAll, 0, 0, 5, 10, 2'b10, 1);
        for (int k = 1; k <= 30; k++) step("sim_wait", 0, 0, 0, MCtl, 0, 0, 0, 0, 2'b10, 0);
        step("inc_plus_dec", 0, 1, 1, MCtl | 6'h0c, 0, 0, 5, 10, 2'b10, 0);
        for (int k = 1; k <= 63; k++) step("sim_wait2", 0, 0, 0, MCtl, 0, 0, 0, 0, 2'b10, 0);
        step("min_abort", 0, 0, 0, MAll, 1, 0, 5, 10, 2'b00, 0);

        cur_hour   = 5'd10;
        cur_minute = 6'd30;
        step("rst_enter", 1, 0, 0, MAll, 0, 0, 10, 30, 2'b01, 1);
        step("rst_min", 1, 0, 0, MAll, 0, 0, 10, 30, 2'b10, 1);
        rstn = 1'b0;
        step("mid_edit_reset", 1, 0, 0, MAll, 1, 0, 0, 0, 2'b00, 0);
        rstn = 1'b1;
        step("post_reset", 0, 0, 0, MAll, 1, 0, 0, 0, 2'b00, 0);

        cur_hour   = 5'd30;
        cur_minute = 6'd45;
        step("clamp_hour", 1, 0, 0, MAll, 0, 0, 0, 45, 2'b01, 1);
        step("clamp_min_go", 1, 0, 0, MAll, 0, 0, 0, 45, 2'b10, 1);
        step("clamp_commit", 1, 0, 0, MAll, 0, 1, 0, 45, 2'b11, 0);
        step("clamp_run", 0, 0, 0, MAll, 1, 0, 0, 45, 2'b00, 0);
        cur_hour   = 5'd12;
        cur_minute = 6'd60;
        step("clamp_minute", 1, 0, 0, MAll, 0, 0, 12, 0, 2'b01, 1);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
